dram_4164_ctrl: RTL and testbench

//  Host-side controller for a byte-wide bank of eight 4164 (64Kx1) DRAMs sharing nras/ncas/nwe.

---
 rtl/dram_4164_ctrl_if.sv | 15 +
 rtl/dram_4164_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_dram_4164_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dram_4164_ctrl_if.sv
// Bus-side interface of the 4164 DRAM controller.
//   req/we/addr/wdata : request from the host (master drives)
//   ready/ack/rdata   : status and read data from the controller (slave drives)
interface dram_4164_ctrl_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ready;
  logic        ack;
  logic [7:0]  rdata;

  modport master (output req, we, addr, wdata, input ready, ack, rdata);
  modport slave  (input req, we, addr, wdata, output ready, ack, rdata);
endinterface

// File: rtl/dram_4164_ctrl.sv
// Host-side controller for a byte-wide bank of eight 4164 (64Kx1) DRAMs.
// Single-byte read/write over a ready/req/ack handshake; generates the
// multiplexed row/column address and RAS/CAS/WE strobes, captures read data.
//
// Ports:
//   clk    : system clock, rising edge
//   nrst   : asynchronous active-low reset
//   bus    : host handshake (req/we/addr/wdata in, ready/ack/rdata out)
//   ma     : multiplexed DRAM address (row = addr[7:0], col = addr[15:8])
//   nras, ncas, nwe : DRAM strobes, active low
//   ram_d  : data to DRAM DI pins
//   ram_q  : data from DRAM DO pins
//
// Build option: define DRAM_REFRESH_EN to add periodic RAS-only refresh
// (REF_PERIOD parameter exists only in that build).
module dram_4164_ctrl #(
  parameter int T_RCD = 2,
  parameter int T_CAS = 4,
  parameter int T_RP  = 3
`ifdef DRAM_REFRESH_EN
  , parameter int REF_PERIOD = 124
`endif
) (
  input  logic                   clk,
  input  logic                   nrst,
  dram_4164_ctrl_if.slave        bus,
  output logic [7:0]             ma,
  output logic                   nras,
  output logic                   ncas,
  output logic                   nwe,
  output logic [7:0]             ram_d,
  input  logic [7:0]             ram_q
);

  typedef enum logic [2:0] {IDLE, ROW, COL, CAS, PRE, RROW, RPRE} state_t;

  // One shared phase counter; the longest phase is the refresh RAS pulse.
  localparam int CW = $clog2(T_RCD + T_CAS + T_RP + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [7:0]    col_q, col_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    ma_q, ma_d;
  logic          nras_q, nras_d;
  logic          ncas_q, ncas_d;
  logic          nwe_q, nwe_d;
  logic [7:0]    ram_d_q, ram_d_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          ack_q, ack_d;

`ifdef DRAM_REFRESH_EN
  localparam int RW = $clog2(REF_PERIOD);
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic          ref_pend_q, ref_pend_d;
  logic [7:0]    ref_row_q, ref_row_d;
  logic          ref_take;
  logic          ref_wrap;

  assign ref_wrap = (ref_cnt_q == RW'(REF_PERIOD - 1));

  // Free-running period counter. A wrap while a refresh is still pending
  // does not queue a second one; a wrap on the take cycle starts a new one.
  always_comb begin
    ref_cnt_d  = ref_wrap ? '0 : ref_cnt_q + 1'b1;
    ref_pend_d = ref_wrap | (ref_pend_q & ~ref_take);
  end

  assign bus.ready = (state_q == IDLE) && !ref_pend_q;
`else
  assign bus.ready = (state_q == IDLE);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    col_d   = col_q;
    wdata_d = wdata_q;
    ma_d    = ma_q;
    nras_d  = nras_q;
    ncas_d  = ncas_q;
    nwe_d   = nwe_q;
    ram_d_d = ram_d_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
`ifdef DRAM_REFRESH_EN
    ref_take  = 1'b0;
    ref_row_d = ref_row_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef DRAM_REFRESH_EN
        if (ref_pend_q) begin
          ref_take = 1'b1;
          ma_d     = ref_row_q;
          nras_d   = 1'b0;
          cnt_d    = '0;
          state_d  = RROW;
        end else
`endif
        if (bus.req) begin
          we_d    = bus.we;
          col_d   = bus.addr[15:8];
          wdata_d = bus.wdata;
          ma_d    = bus.addr[7:0];
          nras_d  = 1'b0;
          cnt_d   = '0;
          state_d = ROW;
        end
      end
      ROW: begin
        // Column address and early-write WE are set up a full cycle before CAS.
        if (cnt_q == CW'(T_RCD - 1)) begin
          ma_d    = col_q;
          nwe_d   = ~we_q;
          ram_d_d = wdata_q;
          cnt_d   = '0;
          state_d = COL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      COL: begin
        ncas_d  = 1'b0;
        cnt_d   = '0;
        state_d = CAS;
      end
      CAS: begin
        if (cnt_q == CW'(T_CAS - 1)) begin
          if (!we_q) rdata_d = ram_q;
          nras_d  = 1'b1;
          ncas_d  = 1'b1;
          nwe_d   = 1'b1;
          ack_d   = 1'b1;
          cnt_d   = '0;
          state_d = PRE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRE: begin
        if (cnt_q == CW'(T_RP - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef DRAM_REFRESH_EN
      RROW: begin
        if (cnt_q == CW'(T_RCD + T_CAS - 1)) begin
          nras_d    = 1'b1;
          ref_row_d = ref_row_q + 1'b1;
          cnt_d     = '0;
          state_d   = RPRE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RPRE: begin
        if (cnt_q == CW'(T_RP - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Reset forces strobes high immediately, aborting any cycle in flight.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      col_q   <= '0;
      wdata_q <= '0;
      ma_q    <= '0;
      nras_q  <= 1'b1;
      ncas_q  <= 1'b1;
      nwe_q   <= 1'b1;
      ram_d_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      col_q   <= col_d;
      wdata_q <= wdata_d;
      ma_q    <= ma_d;
      nras_q  <= nras_d;
      ncas_q  <= ncas_d;
      nwe_q   <= nwe_d;
      ram_d_q <= ram_d_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

`ifdef DRAM_REFRESH_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
      ref_row_q  <= '0;
    end else begin
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      ref_row_q  <= ref_row_d;
    end
  end
`endif

  assign ma        = ma_q;
  assign nras      = nras_q;
  assign ncas      = ncas_q;
  assign nwe       = nwe_q;
  assign ram_d     = ram_d_q;
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dram_4164_ctrl.sv
// Bench for dram_4164_ctrl: behavioural 4164 bank model plus a byte-array
// reference of what the host has written; directed and random accesses.
module tb_dram_4164_ctrl;
  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic [7:0] ma, ram_d;
  wire  [7:0] ram_q;
  logic       nras, ncas, nwe;

  dram_4164_ctrl_if bus();

  dram_4164_ctrl dut (
    .clk(clk), .nrst(nrst), .bus(bus), .ma(ma), .nras(nras), .ncas(ncas),
    .nwe(nwe), .ram_d(ram_d), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // DRAM bank model: row latched at RAS fall, column at CAS fall, early write.
  logic [7:0] mem [0:65535];
  logic [7:0] row_l = 8'h00, col_l = 8'h00;
  always @(negedge nras) begin #1; row_l = ma; end
  always @(negedge ncas) begin
    #1;
    col_l = ma;
    if (!nwe) mem[{col_l, row_l}] = ram_d;
  end
  assign ram_q = (!ncas && nwe) ? mem[{col_l, row_l}] : 8'hzz;

  int vectors = 0;
  int miscompares = 0;

  // Host-side reference: what each address should hold, and the last read value.
  logic [7:0] ref_mem [int];
  logic [7:0] last_rd = 8'h00;

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where ack is seen.
  // lat counts negedges after the accepting edge (ack expected at 8).
  task automatic do_access(input logic w, input logic [15:0] a, input logic [7:0] d,
                           output int lat, output logic saw_nwe);
    int n;
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    n = 0;
    while (!bus.ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("ready_timeout", 0, 1);
    @(posedge clk); #1 bus.req = 1'b0;
    lat = 0; saw_nwe = 1'b0;
    do begin
      @(negedge clk); lat++;
      if (!nwe) saw_nwe = 1'b1;
    end while (!bus.ack && lat < 50);
  endtask

  initial begin
    int lat, gap, cnt, prev_row;
    logic sw, w, prev_nras;
    logic [15:0] a, a2;
    logic [7:0] d;
    logic [15:0] pool [8];

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;

    // Reset state
    #1 nrst = 1'b0;
    #11;
    chk("rst_nras", nras, 1); chk("rst_ncas", ncas, 1); chk("rst_nwe", nwe, 1);
    chk("rst_ma", ma, 0); chk("rst_ram_d", ram_d, 0);
    chk("rst_rdata", bus.rdata, 0); chk("rst_ack", bus.ack, 0);
    @(negedge clk); nrst = 1'b1;
    @(negedge clk);
    chk("rst_ready", bus.ready, 1);

    // Write 0xA4A2 <- 0x5A with strobe ordering checks
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'hA4A2; bus.wdata = 8'h5A;
    @(posedge clk); #1 bus.req = 1'b0;
    lat = 0;
    do begin
      @(negedge clk); lat++;
      if (lat == 1) begin chk("t1_nras_fall", nras, 0); chk("t1_row", ma, 8'hA2); end
      if (lat == 3) begin
        chk("t1_col", ma, 8'hA4); chk("t1_nwe_early", nwe, 0); chk("t1_ncas_high", ncas, 1);
      end
      if (lat == 4) chk("t1_ncas_fall", ncas, 0);
    end while (!bus.ack && lat < 50);
    chk("t1_lat", lat, 8);
    ref_mem[16'hA4A2] = 8'h5A;
    chk("t1_rdata_hold", bus.rdata, last_rd);

    // Read it back
    @(negedge clk);
    do_access(1'b0, 16'hA4A2, 8'h00, lat, sw);
    chk("t2_lat", lat, 8); chk("t2_rdata", bus.rdata, 8'h5A); chk("t2_nwe_idle", sw, 0);
    last_rd = 8'h5A;
    @(negedge clk); chk("t2_ack_width", bus.ack, 0);

    // Back-to-back with req held high
    a2 = 16'h1234; ref_mem[16'h1234] = 8'hC3;
    do_access(1'b1, a2, 8'hC3, lat, sw);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'hA4A2;
    gap = 0;
    do begin @(negedge clk); gap++; end while (!bus.ack && gap < 50);
    bus.addr = a2;
    gap = 0;
    do begin @(negedge clk); gap++; end while (!bus.ready && gap < 50);
`ifndef DRAM_REFRESH_EN
    chk("t3_ready_gap", gap, 3);
`endif
    @(posedge clk); #1 bus.req = 1'b0;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!bus.ack && cnt < 50);
`ifndef DRAM_REFRESH_EN
    chk("t3_ack_gap", gap + cnt, 11);
`endif
    chk("t3_rdata", bus.rdata, 8'hC3);
    last_rd = 8'hC3;

    // Reset during CAS
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'hA4A2;
    cnt = 0;
    while (!bus.ready && cnt < 200) begin @(negedge clk); cnt++; end
    @(posedge clk); #1 bus.req = 1'b0;
    cnt = 0;
    while (ncas && cnt < 50) begin @(negedge clk); cnt++; end
    chk("t4_in_cas", ncas, 0);
    #2 nrst = 1'b0;
    #1;
    chk("t4_nras", nras, 1); chk("t4_ncas", ncas, 1); chk("t4_nwe", nwe, 1);
    chk("t4_rdata", bus.rdata, 0);
    @(negedge clk); nrst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (bus.ack) cnt++; end
    chk("t4_no_ack", cnt, 0); chk("t4_ready", bus.ready, 1);
    last_rd = 8'h00;

    // Random accesses over a small address pool
    for (int i = 0; i < 8; i++) pool[i] = 16'($urandom);
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom);
      a = pool[$urandom_range(0, 7)];
      d = 8'($urandom);
      do_access(w, a, d, lat, sw);
      chk("rnd_lat", lat, 8);
      chk("rnd_nwe", sw, w);
      chk("rnd_addr", {col_l, row_l}, a);
      if (w) ref_mem[int'(a)] = d;
      else   last_rd = ref_rd(a);
      chk("rnd_rdata", bus.rdata, last_rd);
      @(negedge clk);
    end

    // Idle behaviour
    cnt = 0; prev_nras = nras; prev_row = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
`ifdef DRAM_REFRESH_EN
      if (prev_nras && !nras) begin
        if (prev_row >= 0) chk("ref_row_inc", ma, 8'(prev_row + 1));
        prev_row = int'(ma);
        cnt++;
      end
`else
      if (!nras) cnt++;
`endif
      prev_nras = nras;
    end
`ifdef DRAM_REFRESH_EN
    chk("ref_seen", cnt > 0, 1);
`else
    chk("idle_no_ras", cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
